// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control pipe: ALUOp values, funct fields,
// ALU operation codes and the mul/div unit opcode.
package alu_ctrl_pkg;

    localparam logic [2:0] AOP_ANDI  = 3'b000;
    localparam logic [2:0] AOP_BEQ   = 3'b001;
    localparam logic [2:0] AOP_LUI   = 3'b010;
    localparam logic [2:0] AOP_ADDI  = 3'b100;
    localparam logic [2:0] AOP_ORI   = 3'b101;
    localparam logic [2:0] AOP_LDST  = 3'b110;
    localparam logic [2:0] AOP_RTYPE = 3'b111;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;

    typedef enum logic [4:0] {
        OP_AND = 5'd0, OP_OR = 5'd1, OP_NOR = 5'd2, OP_ADD = 5'd3,
        OP_SUB = 5'd4, OP_SLT = 5'd5, OP_XOR = 5'd6, OP_SLLV = 5'd7,
        OP_SLL = 5'd8, OP_SRL = 5'd9, OP_LDST = 5'd10, OP_JR = 5'd11,
        OP_BEQ = 5'd12, OP_LUI = 5'd14, OP_INVALID = 5'd15, OP_MFLO = 5'd16,
        OP_MULT = 5'd17, OP_MULTU = 5'd18, OP_DIV = 5'd19, OP_DIVU = 5'd20,
        OP_MFHI = 5'd21
    } op_e;

    typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11} md_op_e;

    function automatic op_e funct_decode(input logic [5:0] f);
        case (f)
            F_AND:   return OP_AND;
            F_OR:    return OP_OR;
            F_NOR:   return OP_NOR;
            F_ADD:   return OP_ADD;
            F_SUB:   return OP_SUB;
            F_SLT:   return OP_SLT;
            F_XOR:   return OP_XOR;
            F_SLLV:  return OP_SLLV;
            F_SLL:   return OP_SLL;
            F_SRL:   return OP_SRL;
            F_JR:    return OP_JR;
            F_MFHI:  return OP_MFHI;
            F_MFLO:  return OP_MFLO;
            F_MULT:  return OP_MULT;
            F_MULTU: return OP_MULTU;
            F_DIV:   return OP_DIV;
            F_DIVU:  return OP_DIVU;
            default: return OP_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mul/div sequencer: start pulse, latency countdown and a
// one-cycle HI/LO write-back pulse.
module muldiv_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       md_busy,
    output logic       md_done
);
    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;

    // S_DONE keeps busy high for the write-back cycle; a new start may land there.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            md_start <= 1'b0;
            md_op    <= 2'b00;
            md_busy  <= 1'b0;
            md_done  <= 1'b0;
        end else begin
            md_start <= 1'b0;
            md_done  <= 1'b0;
            if (start) begin
                state    <= S_BUSY;
                cnt      <= op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                md_start <= 1'b1;
                md_op    <= op;
                md_busy  <= 1'b1;
            end else begin
                case (state)
                    S_BUSY: begin
                        if (cnt == '0) begin
                            state   <= S_DONE;
                            md_done <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        state   <= S_IDLE;
                        md_busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU control: ALUOp/funct decode into the ID/EX register with
// stall/flush handling and HI/LO interlock against the mul/div sequencer.
module alu_control_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_WIDTH = 3,
    parameter int OP_WIDTH    = 5,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [ALUOP_WIDTH-1:0] alu_op,
    input  logic [5:0]             alu_function,
    input  logic                   stall_in,
    input  logic                   flush,
    output logic [OP_WIDTH-1:0]    alu_operation,
    output logic                   jr,
    output logic                   out_valid,
    output logic                   stall_out,
    output logic                   md_start,
    output logic [1:0]             md_op,
    output logic                   md_busy,
    output logic                   md_done
);
    op_e    dec;
    md_op_e dec_md;
    logic   is_md, is_hilo, hz, start;

    always_comb begin
        dec = OP_INVALID;
        case (alu_op)
            ALUOP_WIDTH'(AOP_RTYPE): dec = funct_decode(alu_function);
            ALUOP_WIDTH'(AOP_ADDI):  dec = OP_ADD;
            ALUOP_WIDTH'(AOP_ORI):   dec = OP_OR;
            ALUOP_WIDTH'(AOP_ANDI):  dec = OP_AND;
            ALUOP_WIDTH'(AOP_LUI):   dec = OP_LUI;
            ALUOP_WIDTH'(AOP_BEQ):   dec = OP_BEQ;
            ALUOP_WIDTH'(AOP_LDST):  dec = OP_LDST;
            default:                 dec = OP_INVALID;
        endcase
    end

    always_comb begin
        dec_md = MD_MULT;
        is_md  = 1'b1;
        case (dec)
            OP_MULT:  dec_md = MD_MULT;
            OP_MULTU: dec_md = MD_MULTU;
            OP_DIV:   dec_md = MD_DIV;
            OP_DIVU:  dec_md = MD_DIVU;
            default:  is_md  = 1'b0;
        endcase
    end

    // The write-back cycle releases the interlock so the waiter issues back-to-back.
    assign is_hilo   = is_md || dec == OP_MFHI || dec == OP_MFLO;
    assign hz        = in_valid && md_busy && !md_done && is_hilo;
    assign stall_out = stall_in || hz;
    assign start     = !stall_in && !flush && !hz && in_valid && is_md;

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_operation <= OP_WIDTH'(OP_INVALID);
            out_valid     <= 1'b0;
            jr            <= 1'b0;
        end else if (stall_in) begin
            alu_operation <= alu_operation;
        end else if (flush || hz) begin
            alu_operation <= OP_WIDTH'(OP_INVALID);
            out_valid     <= 1'b0;
            jr            <= 1'b0;
        end else begin
            alu_operation <= OP_WIDTH'(dec);
            out_valid     <= in_valid;
            jr            <= in_valid && dec == OP_JR;
        end
    end

    muldiv_sequencer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_seq (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (dec_md),
        .md_start(md_start),
        .md_op   (md_op),
        .md_busy (md_busy),
        .md_done (md_done)
    );

endmodule
